// File: rtl/traffic_pkg.sv
// Shared lane constants, emergency FSM states and lane-to-bus packing
// for the intersection model.
package traffic_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned COUNT_W   = 8;
    localparam int unsigned LANES_W   = NUM_LANES * COUNT_W;

    localparam logic [2:0] LANE_S1 = 3'd0;
    localparam logic [2:0] LANE_S2 = 3'd1;
    localparam logic [2:0] LANE_E1 = 3'd2;
    localparam logic [2:0] LANE_E2 = 3'd3;
    localparam logic [2:0] LANE_N1 = 3'd4;
    localparam logic [2:0] LANE_N2 = 3'd5;
    localparam logic [2:0] LANE_W1 = 3'd6;
    localparam logic [2:0] LANE_W2 = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GREEN,
        PASSING
    } emg_state_t;

    // Bus order is {w1,w2,s1,s2,e1,e2,n1,n2}: slot = (5 - lane) mod 8.
    function automatic logic [5:0] lane_lsb(input logic [2:0] lane);
        logic [2:0] slot;
        slot = 3'd5 - lane;
        return {slot, 3'b000};
    endfunction

endpackage

// File: rtl/lane_queue.sv
// One lane's saturating car counter: adds arrivals, removes one car per
// departure tick while the lane is green and non-empty.
module lane_queue
    import traffic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] add,
    input  logic               dep_en,
    input  logic               tick,
    output logic [COUNT_W-1:0] count,
    output logic               departed
);

    logic [COUNT_W:0]   sum;
    logic [COUNT_W-1:0] count_next;

    always_comb begin
        departed   = tick && dep_en && (count != '0);
        sum        = {1'b0, count} + {1'b0, add} - {{COUNT_W{1'b0}}, departed};
        count_next = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/lane_traffic_model.sv
// Closed-loop intersection model: lane queues driven by arrivals and the
// controller's lights, plus an emergency vehicle that waits for its green.
module lane_traffic_model
    import traffic_pkg::*;
#(
    parameter int unsigned DEPART_PERIOD   = 4,
    parameter int unsigned EMG_PASS_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         trafficLightOutput,
    input  logic               arrivalValid,
    input  logic [2:0]         arrivalLane,
    input  logic [7:0]         arrivalCount,
    input  logic               emgReq,
    input  logic [2:0]         emgReqLane,
    output logic [LANES_W-1:0] lanes,
    output logic               emgSignal,
    output logic [7:0]         emgLane,
    output logic               emgBusy,
    output logic [15:0]        departedTotal
);

    localparam int unsigned PRESC_W = (DEPART_PERIOD > 1) ? $clog2(DEPART_PERIOD) : 1;
    localparam int unsigned PASS_W  = $clog2(EMG_PASS_CYCLES + 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;

    logic [COUNT_W-1:0] add   [NUM_LANES];
    logic [COUNT_W-1:0] count [NUM_LANES];
    logic [NUM_LANES-1:0] departed;
    logic [15:0]        dep_sum;

    emg_state_t         state, state_next;
    logic [2:0]         emg_idx, emg_idx_next;
    logic [PASS_W-1:0]  pass_cnt, pass_cnt_next;
    logic               lane_green;
    logic               busy;

    assign tick = (presc == PRESC_W'(DEPART_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign add[i] = (arrivalValid && (arrivalLane == 3'(i))) ? arrivalCount : '0;

        lane_queue u_queue (
            .clk      (clk),
            .rst      (rst),
            .add      (add[i]),
            .dep_en   (trafficLightOutput[i]),
            .tick     (tick),
            .count    (count[i]),
            .departed (departed[i])
        );
    end

    always_comb begin
        lanes = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lanes[lane_lsb(3'(i)) +: COUNT_W] = count[i];
        end
    end

    always_comb begin
        dep_sum = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            dep_sum = dep_sum + 16'(departed[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            departedTotal <= '0;
        end else begin
            departedTotal <= departedTotal + dep_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            emg_idx  <= '0;
            pass_cnt <= '0;
        end else begin
            state    <= state_next;
            emg_idx  <= emg_idx_next;
            pass_cnt <= pass_cnt_next;
        end
    end

    // The green cycle that ends WAIT_GREEN is the first of the pass run,
    // so the counter restarts at 1 rather than 0.
    always_comb begin
        state_next    = state;
        emg_idx_next  = emg_idx;
        pass_cnt_next = pass_cnt;
        lane_green    = trafficLightOutput[emg_idx];
        case (state)
            IDLE: begin
                if (emgReq) begin
                    emg_idx_next = emgReqLane;
                    state_next   = WAIT_GREEN;
                end
            end
            WAIT_GREEN: begin
                if (lane_green) begin
                    pass_cnt_next = PASS_W'(1);
                    state_next    = (EMG_PASS_CYCLES == 1) ? IDLE : PASSING;
                end
            end
            PASSING: begin
                if (!lane_green) begin
                    state_next = WAIT_GREEN;
                end else if (pass_cnt == PASS_W'(EMG_PASS_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    pass_cnt_next = pass_cnt + PASS_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        emgBusy   = busy;
        emgSignal = busy;
        emgLane   = busy ? (8'd1 << emg_idx) : '0;
    end

endmodule

// File: tb/tb_lane_traffic_model.sv
// Directed bench for lane_traffic_model with hand-computed expectations.
module tb_lane_traffic_model;

    logic        clk;
    logic        rst;
    logic [7:0]  lights;
    logic        arr_valid;
    logic [2:0]  arr_lane;
    logic [7:0]  arr_count;
    logic        emg_req;
    logic [2:0]  emg_req_lane;
    logic [63:0] lanes;
    logic        emg_signal;
    logic [7:0]  emg_lane;
    logic        emg_busy;
    logic [15:0] departed_total;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int ticks;
    int exp_s1;

    lane_traffic_model #(
        .DEPART_PERIOD   (4),
        .EMG_PASS_CYCLES (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .trafficLightOutput (lights),
        .arrivalValid       (arr_valid),
        .arrivalLane        (arr_lane),
        .arrivalCount       (arr_count),
        .emgReq             (emg_req),
        .emgReqLane         (emg_req_lane),
        .lanes              (lanes),
        .emgSignal          (emg_signal),
        .emgLane            (emg_lane),
        .emgBusy            (emg_busy),
        .departedTotal      (departed_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edges, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic arrive(input logic [2:0] lane, input logic [7:0] cnt);
        arr_valid = 1'b1;
        arr_lane  = lane;
        arr_count = cnt;
    endtask

    initial begin
        rst = 1'b0; lights = 8'h00; arr_valid = 1'b0; arr_lane = 3'd0;
        arr_count = 8'd0; emg_req = 1'b0; emg_req_lane = 3'd0;
        step();
        step();
        check("reset_lanes", lanes, 64'h0);
        check("reset_busy", {63'd0, emg_busy}, 64'd0);
        check("reset_emg_lane", {56'd0, emg_lane}, 64'd0);
        rst = 1'b1;
        edges = 0;

        // Idle with all lights red.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_lanes", lanes, 64'h0);
            check("idle_emg", {63'd0, emg_signal}, 64'd0);
        end
        check("idle_departed", {48'd0, departed_total}, 64'd0);

        // s1 gets 10 cars and a permanent green; ticks at edges 24,28,...
        lights = 8'h01;
        arrive(3'd0, 8'd10);
        for (int n = 21; n <= 64; n++) begin
            step();
            arr_valid = 1'b0;
            ticks  = (n - 20) / 4;
            exp_s1 = (ticks >= 10) ? 0 : 10 - ticks;
            check("s1_drain", {56'd0, lanes[47:40]}, 64'(exp_s1));
        end
        check("s1_departed", {48'd0, departed_total}, 64'd10);

        // Saturation on w2, same-cycle arrival and departure on s2.
        lights = 8'h00;
        arrive(3'd7, 8'd250);
        step();
        check("w2_250", {56'd0, lanes[55:48]}, 64'd250);
        arrive(3'd7, 8'd20);
        step();
        check("w2_sat", {56'd0, lanes[55:48]}, 64'd255);
        arrive(3'd1, 8'd3);
        step();
        check("s2_3", {56'd0, lanes[39:32]}, 64'd3);
        arrive(3'd1, 8'd5);
        lights = 8'h02;
        step();
        check("s2_add_dep", {56'd0, lanes[39:32]}, 64'd7);
        check("dep_11", {48'd0, departed_total}, 64'd11);
        arr_valid = 1'b0;
        lights = 8'h00;
        step(); step(); step();
        check("s2_hold", {56'd0, lanes[39:32]}, 64'd7);
        arrive(3'd7, 8'd1);
        lights = 8'h82;
        step();
        check("w2_sat_dep", {56'd0, lanes[55:48]}, 64'd255);
        check("s2_dep", {56'd0, lanes[39:32]}, 64'd6);
        check("dep_13", {48'd0, departed_total}, 64'd13);
        arr_valid = 1'b0;

        // Emergency on e1: waits 10 red cycles, clears after 3 greens.
        lights = 8'h00;
        emg_req = 1'b1;
        emg_req_lane = 3'd2;
        step();
        emg_req = 1'b0;
        check("e1_signal", {63'd0, emg_signal}, 64'd1);
        check("e1_lane", {56'd0, emg_lane}, 64'h04);
        check("e1_busy", {63'd0, emg_busy}, 64'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("e1_wait", {55'd0, emg_signal, emg_lane}, {55'd0, 1'b1, 8'h04});
        end
        lights = 8'h04;
        step();
        check("e1_green1", {63'd0, emg_signal}, 64'd1);
        step();
        check("e1_green2", {63'd0, emg_signal}, 64'd1);
        step();
        check("e1_clear_sig", {63'd0, emg_signal}, 64'd0);
        check("e1_clear_lane", {56'd0, emg_lane}, 64'h00);
        check("e1_clear_busy", {63'd0, emg_busy}, 64'd0);

        // Emergency on n1: green run interrupted, second request ignored.
        lights = 8'h00;
        emg_req = 1'b1;
        emg_req_lane = 3'd4;
        step();
        emg_req = 1'b0;
        check("n1_lane", {56'd0, emg_lane}, 64'h10);
        lights = 8'h10;
        step();
        check("n1_g1", {63'd0, emg_busy}, 64'd1);
        emg_req = 1'b1;
        emg_req_lane = 3'd6;
        step();
        emg_req = 1'b0;
        check("n1_ignore_req", {56'd0, emg_lane}, 64'h10);
        lights = 8'h00;
        step();
        check("n1_red", {63'd0, emg_busy}, 64'd1);
        lights = 8'h10;
        step();
        check("n1_rg1", {63'd0, emg_busy}, 64'd1);
        step();
        check("n1_rg2", {63'd0, emg_busy}, 64'd1);
        step();
        check("n1_clear", {63'd0, emg_busy}, 64'd0);
        check("n1_clear_sig", {63'd0, emg_signal}, 64'd0);

        // Reset mid-PASSING on e2 with loaded lanes.
        lights = 8'h00;
        emg_req = 1'b1;
        emg_req_lane = 3'd3;
        step();
        emg_req = 1'b0;
        lights = 8'h08;
        step();
        check("e2_busy", {63'd0, emg_busy}, 64'd1);
        check("pre_rst_lanes", lanes, 64'h00FF_0006_0000_0000);
        rst = 1'b0;
        step();
        check("rst_lanes", lanes, 64'h0);
        check("rst_sig", {63'd0, emg_signal}, 64'd0);
        check("rst_busy", {63'd0, emg_busy}, 64'd0);
        check("rst_departed", {48'd0, departed_total}, 64'd0);
        rst = 1'b1;
        edges = 0;
        lights = 8'h01;
        arrive(3'd0, 8'd5);
        step();
        arr_valid = 1'b0;
        check("post_rst_s1", {56'd0, lanes[47:40]}, 64'd5);
        step(); step();
        check("post_rst_no_tick", {56'd0, lanes[47:40]}, 64'd5);
        step();
        check("post_rst_tick", {56'd0, lanes[47:40]}, 64'd4);
        check("post_rst_dep", {48'd0, departed_total}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_traffic_model.md
Name: lane_traffic_model

Overview:
- Behavioural-synthesizable intersection model on the far end of the controller interface.
- Consumes the controller's 8-bit traffic light vector and produces the 64-bit packed lane car counts, plus the emergency request the controller reads.
- Per-lane car queues fill from arrival requests and drain while that lane's light is green.
- Closes the loop so controller benches run without hand-scripted lane values.

Parameters:
DEPART_PERIOD, 4, cycles between departure ticks; each green lane loses one car per tick (must be >=1).
EMG_PASS_CYCLES, 3, consecutive green cycles the emergency vehicle needs to clear its lane (must be >=1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low
trafficLightOutput  input  8  controller lights, 1=green; bit map 0=s1 1=s2 2=e1 3=e2 4=n1 5=n2 6=w1 7=w2
arrivalValid  input  1  add cars this cycle
arrivalLane  input  3  lane index, same bit map as trafficLightOutput
arrivalCount  input  8  cars to add
emgReq  input  1  one-cycle pulse: inject emergency vehicle
emgReqLane  input  3  lane index for injected emergency vehicle
lanes  output  64  packed counts {w1,w2,s1,s2,e1,e2,n1,n2}; w1=[63:56], n2=[7:0]
emgSignal  output  1  emergency present, to controller
emgLane  output  8  one-hot lane of the emergency vehicle, bit map as trafficLightOutput
emgBusy  output  1  emergency FSM not IDLE
departedTotal  output  16  cars departed since reset, wraps modulo 2^16

Behaviour:
- All state is registered. rst==0 at a clock edge clears all state:
  - all lane counts 0, prescaler 0, departedTotal 0
  - FSM to IDLE, emgSignal 0, emgLane 0, emgBusy 0
- Reset asserted mid-operation discards pending arrivals and emergencies immediately.
- Counts are 8-bit unsigned per lane.
- Prescaler and departure ticks:
  - Prescaler counts 0..DEPART_PERIOD-1, wraps.
  - tick=1 in the cycle the prescaler equals DEPART_PERIOD-1, so the first tick falls in the DEPART_PERIOD-th cycle after reset release.
- Per-lane next-count math, one cycle latency:
  - add = arrivalCount when arrivalValid and arrivalLane==lane, else 0
  - dep = 1 when tick, trafficLightOutput[lane]==1, and count>0, else 0
  - next = count + add - dep, computed at 9+ bits and saturated to 255
  - A count of 0 never underflows; a green lane at 0 gets dep=0.
  - Arrival and departure on the same lane in the same cycle: both apply, e.g. 255+1-1=255 and 254+5-1=255 (saturate).
- departedTotal increments by the number of lanes with dep=1 that cycle (0..8).
- lanes updates the cycle after the arrival or tick; outputs are never combinational from inputs.
- Emergency FSM:
  - IDLE:
    - emgReq=1 latches emgReqLane; next state WAIT_GREEN.
    - Next cycle: emgSignal=1, emgLane=one-hot(latched lane), emgBusy=1.
  - WAIT_GREEN:
    - If trafficLightOutput[lane]==1, clear the pass counter and go to PASSING.
  - PASSING:
    - The pass counter increments each cycle the lane is green.
    - If the lane goes red, return to WAIT_GREEN (counter restarts on the next green).
    - When EMG_PASS_CYCLES consecutive green cycles complete, go to IDLE; emgSignal, emgLane and emgBusy drop to 0 the following cycle.
  - emgReq outside IDLE is ignored; there is no queueing.
  - emgReq in the same cycle the FSM returns to IDLE is also ignored.
  - The emergency vehicle does not change lane counts.
- An out-of-range index cannot occur (3-bit index, 8 lanes).

Decomposition:
- Shared package traffic_pkg holds:
  - lane index constants LANE_S1..LANE_W2 (0..7)
  - NUM_LANES=8, COUNT_W=8
  - the emergency FSM state enum {IDLE, WAIT_GREEN, PASSING}
  - the lane-to-bus packing function (lane index -> bit slice of lanes)
- One natural sub-module, lane_queue: a single saturating 8-bit up/down counter. It takes add, dep_en and tick, outputs count and a departed flag, and is instantiated 8 times.
- The prescaler, FSM and departedTotal adder stay in the top module.

Test Plan:
- Reset then idle 20 cycles, lights 8'h00 -> lanes=64'h0, departedTotal=0, emgSignal=0 throughout.
- Arrival lane 0 (s1), count 10; lights 8'h01 from then on; DEPART_PERIOD=4 -> lanes[47:40]:
  - 10 one cycle after the arrival
  - drops by 1 every 4 cycles, holds at 0 after 10 ticks
  - departedTotal=10
- Arrival lane 7 (w2) count 250, then count 20 -> lanes[55:48]=255 (saturated). Same-cycle arrival 5 with tick and green on a lane holding 3 -> 7.
- emgReq lane 2 (e1) with lights 8'h00 for 10 cycles -> emgSignal=1 and emgLane=8'b00000100 one cycle after the request, held for the full 10 cycles. Then lights=8'h04 for 3 cycles -> emgSignal=0 one cycle after the third green.
- Emergency on lane 4: green 2 cycles, red 1 cycle, green 3 cycles -> FSM goes PASSING->WAIT_GREEN->PASSING and clears only after the second green run. A second emgReq while busy is ignored (emgLane unchanged).
- rst=0 for one cycle mid-PASSING with lanes nonzero -> next cycle all lanes 0, emgSignal 0, emgBusy 0, departedTotal 0, prescaler restarts (first tick 4 cycles later).
